// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Definitions shared by the ALU execution units (adder,
//                divider, sequential multiplier): the multi-cycle unit state
//                encoding and the CPSR flag bit positions used when the
//                units assemble their N/Z/C/V flag vectors.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Multi-cycle unit control states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  // CPSR flag vector layout {N, Z, C, V}
  localparam int FLAG_W        = 4;
  localparam int FLAG_OVERFLOW = 0;
  localparam int FLAG_COUT     = 1;
  localparam int FLAG_ZERO     = 2;
  localparam int FLAG_NEGATIVE = 3;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/magnitude_conv.sv
`default_nettype none
// ============================================================================
//  Module      : magnitude_conv
//  Description : Conditional two's-complement negation. Produces -v when
//                neg is set, otherwise passes v through. Used both to take
//                operand magnitudes and to re-apply the sign to a product.
//  Ports       : neg    in   1      negate request
//                v      in   WIDTH  input value
//                result out  WIDTH  neg ? (~v)+1 : v
//  Revision    : 1.0  initial release
// ============================================================================
module magnitude_conv #(
  parameter int WIDTH = 16
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] result
);

  // The most negative input negates to itself; read as unsigned that is
  // exactly its magnitude 2^(WIDTH-1), which is what the multiplier wants.
  assign result = neg ? (~v + WIDTH'(1)) : v;

endmodule : magnitude_conv
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Iterative signed shift-add multiplier. Operand magnitudes
//                are multiplied one partial product per clock, then the
//                sign is applied in a final FIX cycle that also registers
//                the product and its CPSR flags and pulses done.
//                Latency from the start edge to done is WIDTH+1 cycles.
//  Ports       : clk        in   1        rising-edge clock
//                rst        in   1        asynchronous active-high reset
//                start      in   1        request, sampled only when idle
//                x          in   WIDTH    multiplicand (signed)
//                y          in   WIDTH    multiplier (signed)
//                busy       out  1        operation in progress
//                done       out  1        one-cycle result-valid pulse
//                prod       out  WIDTH    low half of the signed product
//                prod_full  out  2*WIDTH  full signed product
//                negative   out  1        product < 0
//                zero       out  1        product == 0
//                cout       out  1        always 0
//                overflow   out  1        product does not fit WIDTH signed
//  Revision    : 1.0  initial release
// ============================================================================
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   prod,
  output logic [2*WIDTH-1:0] prod_full,
  output logic               negative,
  output logic               zero,
  output logic               cout,
  output logic               overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [FLAG_W-1:0] FLAGS_RESET = FLAG_W'(1 << FLAG_ZERO);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mag_x;
  logic [WIDTH-1:0]   r_mag_y;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_sign;
  logic               r_done;
  logic [2*WIDTH-1:0] r_prod_full;
  logic [FLAG_W-1:0]  r_flags;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   w_mag_x;
  logic [WIDTH-1:0]   w_mag_y;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_result;
  logic [WIDTH:0]     w_ovf_bits;
  logic               w_overflow;

  magnitude_conv #(.WIDTH(WIDTH)) u_mag_x (
    .neg    (x[WIDTH-1]),
    .v      (x),
    .result (w_mag_x)
  );

  magnitude_conv #(.WIDTH(WIDTH)) u_mag_y (
    .neg    (y[WIDTH-1]),
    .v      (y),
    .result (w_mag_y)
  );

  magnitude_conv #(.WIDTH(2*WIDTH)) u_fix (
    .neg    (r_sign),
    .v      (r_acc),
    .result (w_result)
  );

  // Upper accumulator half plus the current partial product. The extra bit
  // keeps the carry so it can be shifted back in at the top.
  assign w_addend = r_mag_y[0] ? r_mag_x : '0;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

  // The product fits WIDTH signed bits only if the top WIDTH+1 bits are a
  // pure sign extension.
  assign w_ovf_bits = w_result[2*WIDTH-1:WIDTH-1];
  assign w_overflow = ~((&w_ovf_bits) | ~(|w_ovf_bits));

  // --------------------------------------------------------------------------
  // Control FSM, counter and shift-add datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mag_x     <= '0;
      r_mag_y     <= '0;
      r_acc       <= '0;
      r_sign      <= 1'b0;
      r_done      <= 1'b0;
      r_prod_full <= '0;
      r_flags     <= FLAGS_RESET;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mag_x <= w_mag_x;
            r_mag_y <= w_mag_y;
            r_sign  <= x[WIDTH-1] ^ y[WIDTH-1];
            r_acc   <= '0;
            r_cnt   <= CNT_W'(WIDTH);
            r_state <= RUN;
          end
        end

        RUN: begin
          // Shift {carry, acc_hi, acc_lo, mag_y} right by one; the consumed
          // multiplier bit drops out of the bottom of mag_y.
          r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
          r_mag_y <= {r_acc[0], r_mag_y[WIDTH-1:1]};
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= FIX;
          end
        end

        FIX: begin
          r_prod_full                <= w_result;
          r_flags[FLAG_NEGATIVE]     <= w_result[2*WIDTH-1];
          r_flags[FLAG_ZERO]         <= (w_result == '0);
          r_flags[FLAG_COUT]         <= 1'b0;
          r_flags[FLAG_OVERFLOW]     <= w_overflow;
          r_done                     <= 1'b1;
          r_state                    <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy      = (r_state == RUN) || (r_state == FIX);
  assign done      = r_done;
  assign prod_full = r_prod_full;
  assign prod      = r_prod_full[WIDTH-1:0];
  assign negative  = r_flags[FLAG_NEGATIVE];
  assign zero      = r_flags[FLAG_ZERO];
  assign cout      = r_flags[FLAG_COUT];
  assign overflow  = r_flags[FLAG_OVERFLOW];

endmodule : seq_multiplier
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_multiplier
//  Description : Directed self-checking bench for seq_multiplier (WIDTH=16)
//                with hand-computed products, flags and latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_multiplier;

  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0] prod_full;
  logic               negative;
  logic               zero;
  logic               cout;
  logic               overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .prod      (prod),
    .prod_full (prod_full),
    .negative  (negative),
    .zero      (zero),
    .cout      (cout),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Issue one multiply (start is driven #1 after an edge, so it is sampled
  // by the next edge) and check latency, results and flags.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_full, input logic [15:0] exp_prod,
                        input logic exp_n, input logic exp_z, input logic exp_v,
                        input bit mid_start);
    int  lat;
    bit  seen;
    x = a; y = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Operand changes after the start edge must have no effect.
    x = 16'h1234; y = 16'h4321;
    check({tag, ".done_low_at_start"}, 64'(done), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd1);
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      start = (mid_start && k == 5);
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    start = 1'b0;
    check({tag, ".latency"},   64'(lat),       64'd17);
    check({tag, ".prod_full"}, 64'(prod_full), 64'(exp_full));
    check({tag, ".prod"},      64'(prod),      64'(exp_prod));
    check({tag, ".negative"},  64'(negative),  64'(exp_n));
    check({tag, ".zero"},      64'(zero),      64'(exp_z));
    check({tag, ".overflow"},  64'(overflow),  64'(exp_v));
    check({tag, ".cout"},      64'(cout),      64'd0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy",      64'(busy),      64'd0);
    check("rst.done",      64'(done),      64'd0);
    check("rst.prod",      64'(prod),      64'd0);
    check("rst.prod_full", 64'(prod_full), 64'd0);
    check("rst.negative",  64'(negative),  64'd0);
    check("rst.zero",      64'(zero),      64'd1);
    check("rst.cout",      64'(cout),      64'd0);
    check("rst.overflow",  64'(overflow),  64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: each op starts in the IDLE cycle right after done.
    run_op("7x6",         16'd7,    16'd6,    32'd42,        16'd42,   1'b0, 1'b0, 1'b0, 1'b0);
    run_op("0xm9",        16'd0,    16'hFFF7, 32'd0,         16'd0,    1'b0, 1'b1, 1'b0, 1'b0);
    run_op("m3x5",        16'hFFFD, 16'd5,    32'hFFFFFFF1,  16'hFFF1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("min_x1",      16'h8000, 16'd1,    32'hFFFF8000,  16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("min_xm1",     16'h8000, 16'hFFFF, 32'h00008000,  16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of an operation.
    x = 16'd300; y = 16'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst.busy",      64'(busy),      64'd0);
    check("midrst.done",      64'(done),      64'd0);
    check("midrst.prod",      64'(prod),      64'd0);
    check("midrst.prod_full", 64'(prod_full), 64'd0);
    check("midrst.negative",  64'(negative),  64'd0);
    check("midrst.zero",      64'(zero),      64'd1);
    check("midrst.overflow",  64'(overflow),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst.no_done", 64'(ndone), 64'd0);

    // Fresh start, with a start pulse mid-RUN that must be ignored.
    run_op("300x200", 16'd300, 16'd200, 32'h0000EA60, 16'hEA60, 1'b0, 1'b0, 1'b1, 1'b1);
    ndone = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("300x200.single_done", 64'(ndone), 64'd0);
    check("300x200.idle_busy",   64'(busy),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_seq_multiplier
`default_nettype wire
